// File: rtl/laser_pkg.sv
// Shared definitions for the laser point sequencer: point field layout,
// DAC word layout, FSM state encoding and the DAC word builder.
package laser_pkg;

  localparam int PT_RGB_LSB      = 24;
  localparam int RGB_W           = 3;
  localparam int PT_X_LSB        = 12;
  localparam int PT_Y_LSB        = 0;
  localparam int COORD_W         = 12;
  localparam int DAC_WORD_W      = 16;
  localparam int DAC_AB_BIT      = 15;
  localparam int DAC_CFG_LSB     = 12;
  localparam int DEFAULT_CLK_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_X,
    ST_GAP,
    ST_SHIFT_Y,
    ST_LATCH,
    ST_DWELL
  } seq_state_t;

  function automatic logic [DAC_WORD_W-1:0] dac_word(input logic ab,
                                                     input logic [2:0] cfg,
                                                     input logic [COORD_W-1:0] coord);
    logic [DAC_WORD_W-1:0] w;
    w = '0;
    w[DAC_AB_BIT] = ab;
    w[DAC_CFG_LSB +: 3] = cfg;
    w[COORD_W-1:0] = coord;
    return w;
  endfunction

endpackage

// File: rtl/laser_point_sequencer_if.sv
// DAC SPI pins and laser colour outputs of the point sequencer.
interface laser_point_sequencer_if;
  logic                         dac_csn;
  logic                         dac_latchn;
  logic                         dac_sclk;
  logic                         dac_mosi;
  logic [laser_pkg::RGB_W-1:0]  laser_rgb;

  modport master (output dac_csn, dac_latchn, dac_sclk, dac_mosi, laser_rgb);
  modport slave  (input  dac_csn, dac_latchn, dac_sclk, dac_mosi, laser_rgb);
endinterface

// File: rtl/point_fifo.sv
// Synchronous point FIFO with registered read data; a write while full is
// accepted only when a read happens in the same cycle.
module point_fifo #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/laser_point_sequencer.sv
// Pops points from a FIFO and clocks X then Y words into a dual serial DAC,
// latches both outputs, lights the laser colour and holds for a dwell time.
module laser_point_sequencer import laser_pkg::*; #(
  parameter int         CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [2:0] DAC_CFG    = 3'b111
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        pt_wr,
  input  logic [31:0]                 pt_data,
  input  logic [15:0]                 dwell_cycles,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        overflow,
  output logic                        underrun,
  laser_point_sequencer_if.master     dac
);

  localparam int          PT_STORE_W = PT_RGB_LSB + RGB_W;
  localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(2 * CLK_DIV - 1);

  seq_state_t            state, state_n;
  logic [15:0]           tcnt, tcnt_n;
  logic                  sclk_q, sclk_n;
  logic [3:0]            bit_cnt, bit_n;
  logic [15:0]           dwell_q;
  logic [RGB_W-1:0]      rgb_q;
  logic                  underrun_q, underrun_n;
  logic                  overflow_q;
  logic                  rgb_set, rgb_clr, point_done;
  logic                  pop, shifting;
  logic [PT_STORE_W-1:0] pt_head;
  logic [DAC_WORD_W-1:0] cur_word;
  logic                  unused_pt_bits;

  assign unused_pt_bits = ^pt_data[31:PT_STORE_W];
  assign pop = (state == ST_LOAD);

  // The FIFO read register doubles as the current-point register: it only
  // changes on the LOAD pop, so x/y/rgb stay stable for the whole point.
  point_fifo #(
    .DATA_W (PT_STORE_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pt_wr),
    .wr_data (pt_data[PT_STORE_W-1:0]),
    .rd_en   (pop),
    .rd_data (pt_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt + 16'd1;
    sclk_n     = sclk_q;
    bit_n      = bit_cnt;
    rgb_set    = 1'b0;
    rgb_clr    = 1'b0;
    point_done = 1'b0;
    underrun_n = 1'b0;
    case (state)
      ST_IDLE: begin
        tcnt_n = '0;
        if (enable && !fifo_empty) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        tcnt_n  = '0;
        sclk_n  = 1'b0;
        bit_n   = '0;
        state_n = ST_SHIFT_X;
      end
      ST_SHIFT_X, ST_SHIFT_Y: begin
        if (tcnt == HALF_LAST) begin
          tcnt_n = '0;
          sclk_n = ~sclk_q;
          if (sclk_q) begin
            bit_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state_n = (state == ST_SHIFT_X) ? ST_GAP : ST_LATCH;
          end
        end
      end
      ST_GAP: begin
        if (tcnt == GAP_LAST) begin
          tcnt_n  = '0;
          state_n = ST_SHIFT_Y;
        end
      end
      ST_LATCH: begin
        if (tcnt == HALF_LAST) begin
          tcnt_n  = '0;
          rgb_set = 1'b1;
          if (dwell_q != '0) state_n = ST_DWELL;
          else               point_done = 1'b1;
        end
      end
      ST_DWELL: begin
        if (tcnt == dwell_q - 16'd1) point_done = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Going idle blanks the beam; it only counts as an underrun while enabled.
    if (point_done) begin
      if (enable && !fifo_empty) begin
        state_n = ST_LOAD;
      end else begin
        state_n    = ST_IDLE;
        rgb_clr    = 1'b1;
        underrun_n = enable;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      tcnt       <= '0;
      sclk_q     <= 1'b0;
      bit_cnt    <= '0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      sclk_q     <= sclk_n;
      bit_cnt    <= bit_n;
      underrun_q <= underrun_n;
      overflow_q <= pt_wr && fifo_full && !pop;
      if (rgb_clr)      rgb_q <= '0;
      else if (rgb_set) rgb_q <= pt_head[PT_RGB_LSB +: RGB_W];
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD) dwell_q <= dwell_cycles;
  end

  assign shifting = (state == ST_SHIFT_X) || (state == ST_SHIFT_Y);
  assign cur_word = (state == ST_SHIFT_Y) ?
                    dac_word(1'b1, DAC_CFG, pt_head[PT_Y_LSB +: COORD_W]) :
                    dac_word(1'b0, DAC_CFG, pt_head[PT_X_LSB +: COORD_W]);

  // MOSI steps with bit_cnt, which only advances on the edge SCLK falls.
  assign dac.dac_csn    = !shifting;
  assign dac.dac_sclk   = shifting && sclk_q;
  assign dac.dac_mosi   = shifting && cur_word[~bit_cnt];
  assign dac.dac_latchn = (state != ST_LATCH);
  assign dac.laser_rgb  = rgb_q;

  assign busy     = (state != ST_IDLE);
  assign overflow = overflow_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_laser_point_sequencer.sv
// Scoreboard bench: expected DAC words and laser colours are queued when a
// point is pushed and compared as the SPI/latch monitor observes them.
module tb_laser_point_sequencer;

  localparam int         CLK_DIV    = 2;
  localparam int         FIFO_DEPTH = 16;
  localparam logic [2:0] DAC_CFG    = 3'b111;
  localparam int         LW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pt_wr;
  logic [31:0]   pt_data;
  logic [15:0]   dwell_cycles;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          busy;
  logic          overflow;
  logic          underrun;

  laser_point_sequencer_if dac_if ();

  laser_point_sequencer #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DAC_CFG    (DAC_CFG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pt_wr        (pt_wr),
    .pt_data      (pt_data),
    .dwell_cycles (dwell_cycles),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .overflow     (overflow),
    .underrun     (underrun),
    .dac          (dac_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_word_q[$];
  logic [2:0]  exp_rgb_q[$];

  int          cyc = 0;
  int          n_busy = 0;
  int          n_over = 0;
  int          n_under = 0;
  int          n_latch = 0;
  int          lat_run = 0;
  int          bits_m = 0;
  logic [15:0] sh_m = '0;
  int          latch_cyc_q[$];
  logic        prev_csn = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  logic        prev_latchn = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_pt(input logic [31:0] d, input bit stored, input bit lit);
    pt_wr   = 1'b1;
    pt_data = d;
    if (stored) begin
      exp_word_q.push_back({1'b0, DAC_CFG, d[23:12]});
      exp_word_q.push_back({1'b1, DAC_CFG, d[11:0]});
      exp_rgb_q.push_back(lit ? d[26:24] : 3'b000);
    end
    tick(1);
    pt_wr = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string tag);
    int k;
    k = 0;
    while (busy !== val && k < budget) begin
      tick(1);
      k++;
    end
    check_eq(tag, 32'(busy), 32'(val));
  endtask

  // SPI / latch monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      bits_m      = 0;
      sh_m        = '0;
      lat_run     = 0;
      prev_csn    = 1'b1;
      prev_sclk   = 1'b0;
      prev_mosi   = 1'b0;
      prev_latchn = 1'b1;
    end else begin
      if (busy)     n_busy++;
      if (overflow) n_over++;
      if (underrun) n_under++;
      if (dac_if.dac_sclk && prev_sclk)
        check_eq("mosi_stable_sclk_high", 32'(dac_if.dac_mosi), 32'(prev_mosi));
      if (dac_if.dac_sclk && !prev_sclk) begin
        sh_m = {sh_m[14:0], dac_if.dac_mosi};
        bits_m++;
      end
      if (dac_if.dac_csn && !prev_csn) begin
        check_eq("spi_bits", bits_m, 16);
        check_eq("spi_word", 32'(sh_m),
                 (exp_word_q.size() > 0) ? 32'(exp_word_q.pop_front()) : 32'hDEAD_BEEF);
        bits_m = 0;
      end
      if (!dac_if.dac_latchn) begin
        lat_run++;
        if (prev_latchn) begin
          n_latch++;
          latch_cyc_q.push_back(cyc);
        end
        check_eq("csn_high_in_latch", 32'(dac_if.dac_csn), 1);
      end
      if (dac_if.dac_latchn && !prev_latchn) begin
        check_eq("latch_len", lat_run, CLK_DIV);
        check_eq("laser_rgb_at_latch", 32'(dac_if.laser_rgb),
                 (exp_rgb_q.size() > 0) ? 32'(exp_rgb_q.pop_front()) : 32'hDEAD_BEEF);
        lat_run = 0;
      end
      prev_csn    = dac_if.dac_csn;
      prev_sclk   = dac_if.dac_sclk;
      prev_mosi   = dac_if.dac_mosi;
      prev_latchn = dac_if.dac_latchn;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, u0, o0, l0, lq0;
    reset        = 1'b0;
    enable       = 1'b0;
    pt_wr        = 1'b0;
    pt_data      = '0;
    dwell_cycles = '0;
    tick(3);
    check_eq("rst_csn",      32'(dac_if.dac_csn), 1);
    check_eq("rst_latchn",   32'(dac_if.dac_latchn), 1);
    check_eq("rst_sclk",     32'(dac_if.dac_sclk), 0);
    check_eq("rst_mosi",     32'(dac_if.dac_mosi), 0);
    check_eq("rst_rgb",      32'(dac_if.laser_rgb), 0);
    check_eq("rst_busy",     32'(busy), 0);
    check_eq("rst_overflow", 32'(overflow), 0);
    check_eq("rst_underrun", 32'(underrun), 0);
    check_eq("rst_level",    32'(fifo_level), 0);
    check_eq("rst_empty",    32'(fifo_empty), 1);
    check_eq("rst_full",     32'(fifo_full), 0);
    reset = 1'b1;
    tick(2);

    // Single point, dwell 100: expect words 0x7123/0xF456 and 235 busy cycles.
    dwell_cycles = 16'd100;
    enable = 1'b1;
    b0 = n_busy;
    u0 = n_under;
    push_pt(32'h0312_3456, 1'b1, 1'b1);
    wait_busy(1'b1, 10, "t1_start");
    wait_busy(1'b0, 400, "t1_done");
    tick(2);
    check_eq("t1_busy_cycles", n_busy - b0, 235);
    check_eq("t1_underrun",    n_under - u0, 1);
    check_eq("t1_rgb_off",     32'(dac_if.laser_rgb), 0);
    check_eq("t1_words_left",  exp_word_q.size(), 0);

    // Fill with 17 points while disabled: one overflow, level 16.
    enable = 1'b0;
    dwell_cycles = 16'd3;
    o0 = n_over;
    for (int i = 0; i < 17; i++) push_pt($urandom, i < 16, 1'b1);
    tick(2);
    check_eq("t2_overflow_cnt", n_over - o0, 1);
    check_eq("t2_level_full",   32'(fifo_level), 16);
    check_eq("t2_full_flag",    32'(fifo_full), 1);

    // Push into the LOAD cycle while full: accepted, level unchanged.
    o0 = n_over;
    enable = 1'b1;
    tick(1);
    check_eq("t2_in_load_busy", 32'(busy), 1);
    push_pt($urandom, 1'b1, 1'b1);
    check_eq("t2_level_load_push", 32'(fifo_level), 16);
    tick(2);
    check_eq("t2_no_overflow", n_over - o0, 0);
    u0 = n_under;
    wait_busy(1'b0, 17 * 150, "t2_drain");
    tick(2);
    check_eq("t2_level_empty", 32'(fifo_level), 0);
    check_eq("t2_empty_flag",  32'(fifo_empty), 1);
    check_eq("t2_underrun",    n_under - u0, 1);

    // Three points with dwell 0: 135-cycle spacing, underrun after the last.
    enable = 1'b0;
    dwell_cycles = 16'd0;
    lq0 = latch_cyc_q.size();
    u0 = n_under;
    push_pt($urandom, 1'b1, 1'b1);
    push_pt($urandom, 1'b1, 1'b1);
    push_pt($urandom, 1'b1, 1'b0);
    enable = 1'b1;
    wait_busy(1'b1, 10, "t3_start");
    wait_busy(1'b0, 600, "t3_done");
    tick(2);
    check_eq("t3_latch_count", latch_cyc_q.size() - lq0, 3);
    if (latch_cyc_q.size() >= lq0 + 3) begin
      check_eq("t3_spacing_1", latch_cyc_q[lq0+1] - latch_cyc_q[lq0], 1 + 67 * CLK_DIV);
      check_eq("t3_spacing_2", latch_cyc_q[lq0+2] - latch_cyc_q[lq0+1], 1 + 67 * CLK_DIV);
    end
    check_eq("t3_underrun", n_under - u0, 1);
    check_eq("t3_rgb_off",  32'(dac_if.laser_rgb), 0);

    // Drop enable during SHIFT_Y of point 1 of 2.
    enable = 1'b0;
    dwell_cycles = 16'd5;
    u0 = n_under;
    l0 = n_latch;
    push_pt($urandom, 1'b1, 1'b1);
    push_pt($urandom, 1'b0, 1'b0);
    enable = 1'b1;
    tick(80);
    check_eq("t4_mid_shift_y_csn", 32'(dac_if.dac_csn), 0);
    enable = 1'b0;
    wait_busy(1'b0, 300, "t4_done");
    tick(2);
    check_eq("t4_latch_count", n_latch - l0, 1);
    check_eq("t4_level",       32'(fifo_level), 1);
    check_eq("t4_no_underrun", n_under - u0, 0);
    check_eq("t4_rgb_off",     32'(dac_if.laser_rgb), 0);
    check_eq("t4_words_left",  exp_word_q.size(), 0);

    // Reset 10 cycles into SHIFT_X of the remaining point.
    l0 = n_latch;
    enable = 1'b1;
    tick(12);
    check_eq("t5_in_shift_x_csn", 32'(dac_if.dac_csn), 0);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_csn",    32'(dac_if.dac_csn), 1);
    check_eq("t5_rst_sclk",   32'(dac_if.dac_sclk), 0);
    check_eq("t5_rst_rgb",    32'(dac_if.laser_rgb), 0);
    check_eq("t5_rst_latchn", 32'(dac_if.dac_latchn), 1);
    check_eq("t5_rst_busy",   32'(busy), 0);
    check_eq("t5_rst_level",  32'(fifo_level), 0);
    tick(3);
    check_eq("t5_no_latch", n_latch - l0, 0);
    reset  = 1'b1;
    enable = 1'b0;
    tick(2);
    check_eq("t5_level_after", 32'(fifo_level), 0);
    check_eq("t5_idle_after",  32'(busy), 0);

    check_eq("sb_words_left", exp_word_q.size(), 0);
    check_eq("sb_rgb_left",   exp_rgb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
